serial_sub8: RTL and testbench

- Byte-serial modular subtractor for the 8-bit SEED datapath: D = (A - B) mod 2^(8*NBYTES).
- Operands are taken one byte pair per handshake, LSB first; the borrow ripples between bytes through a register.
- Inverse partner of the byte-serial adder. The key schedule uses it for the (B - D + KC) and (A + C - KC) style terms.
- Sits between the operand byte muxes and the G-function input register.

---
 rtl/seed_pkg.sv | 27 ++
 rtl/sub8_cell.sv | 22 ++
 rtl/serial_sub8.sv | 124 ++++++++++++
 tb/tb_serial_sub8.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seed_pkg.sv
// Shared definitions for the 8-bit SEED datapath: byte type, word geometry,
// the key-schedule round constants, and the byte-serial subtractor's phase type.
package seed_pkg;

    localparam int BYTE_W      = 8;
    localparam int SEED_NBYTES = 4;

    typedef logic [BYTE_W-1:0] byte_t;

    // Phase of a byte-serial word, decoded from the byte counter.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } word_state_e;

    localparam logic [31:0] KC [16] = '{
        32'h9e3779b9, 32'h3c6ef373, 32'h78dde6e6, 32'hf1bbcdcc,
        32'he3779b99, 32'hc6ef3733, 32'h8dde6e67, 32'h1bbcdccf,
        32'h3779b99e, 32'h6ef3733c, 32'hdde6e678, 32'hbbcdccf1,
        32'h779b99e3, 32'hef3733c6, 32'hde6e678d, 32'hbcdccf1b
    };

    function automatic logic [31:0] kc_const(input logic [3:0] round_idx);
        return KC[round_idx];
    endfunction

endpackage

// File: rtl/sub8_cell.sv
// Combinational 8-bit subtract with borrow in/out; the mirror of the adder cell.
module sub8_cell
    import seed_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              bin,
    output logic [BYTE_W-1:0] d,
    output logic              bout
);

    logic [BYTE_W:0] diff;

    // The 9th bit of the widened difference is set exactly when a < b + bin.
    always_comb begin
        diff = {1'b0, a} - {1'b0, b} - {{BYTE_W{1'b0}}, bin};
    end

    assign d    = diff[BYTE_W-1:0];
    assign bout = diff[BYTE_W];

endmodule

// File: rtl/serial_sub8.sv
// Byte-serial modular subtractor D = (A - B) mod 2^(8*NBYTES), LSB first,
// one-stage valid/ready pipeline. Optional uflow output under SERIAL_SUB_UFLOW_EN.
module serial_sub8
    import seed_pkg::*;
#(
    parameter int NBYTES = SEED_NBYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] A_byte,
    input  logic [BYTE_W-1:0] B_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] D_byte,
    output logic              out_last,
    output logic              busy
`ifdef SERIAL_SUB_UFLOW_EN
    ,
    output logic              uflow
`endif
);

    localparam int              CNT_W    = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    logic              out_valid_q, out_valid_d;
    logic [BYTE_W-1:0] d_byte_q,    d_byte_d;
    logic              out_last_q,  out_last_d;
    logic              borrow_q,    borrow_d;
    logic [CNT_W-1:0]  byte_cnt_q,  byte_cnt_d;

    word_state_e       state;
    logic              accept;
    logic              out_hs;
    logic              bin;
    logic              is_last;
    logic [BYTE_W-1:0] cell_d;
    logic              cell_bout;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign state    = (byte_cnt_q == '0) ? ST_IDLE : ST_RUN;
    assign is_last  = (byte_cnt_q == CNT_LAST);

    // A new word never inherits the borrow left by the previous word's MSB byte.
    assign bin = (state == ST_RUN) ? borrow_q : 1'b0;

    sub8_cell u_cell (
        .a    (A_byte),
        .b    (B_byte),
        .bin  (bin),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        out_valid_d = out_valid_q;
        d_byte_d    = d_byte_q;
        out_last_d  = out_last_q;
        borrow_d    = borrow_q;
        byte_cnt_d  = byte_cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            d_byte_d    = cell_d;
            out_last_d  = is_last;
            borrow_d    = cell_bout;
            byte_cnt_d  = is_last ? '0 : byte_cnt_q + 1'b1;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            d_byte_q    <= '0;
            out_last_q  <= 1'b0;
            borrow_q    <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            d_byte_q    <= d_byte_d;
            out_last_q  <= out_last_d;
            borrow_q    <= borrow_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign D_byte    = d_byte_q;
    assign out_last  = out_last_q;
    assign busy      = (byte_cnt_q != '0) || out_valid_q;

`ifdef SERIAL_SUB_UFLOW_EN
    logic uflow_q, uflow_d;

    // Borrow out of the MSB byte means A < B for the whole unsigned word.
    always_comb begin
        uflow_d = uflow_q;
        if (accept) begin
            uflow_d = is_last && cell_bout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uflow_q <= 1'b0;
        end else begin
            uflow_q <= uflow_d;
        end
    end

    assign uflow = uflow_q;
`endif

endmodule

// File: tb/tb_serial_sub8.sv
// Scoreboard bench for serial_sub8: the driver queues expected bytes on each
// accept, and a monitor pops and compares on every output handshake.
module tb_serial_sub8;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       uf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A_byte = 8'h00;
    logic [7:0] B_byte = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] D_byte;
    logic       out_last;
    logic       busy;
`ifdef SERIAL_SUB_UFLOW_EN
    logic       uflow;
`endif

    serial_sub8 #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_byte    (A_byte),
        .B_byte    (B_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D_byte    (D_byte),
        .out_last  (out_last),
        .busy      (busy)
`ifdef SERIAL_SUB_UFLOW_EN
        ,
        .uflow     (uflow)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycles   = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    exp_t sb[$];

    always @(posedge clk) cycles <= cycles + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every output handshake against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got D=0x%0h with empty scoreboard", D_byte);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_v("d_byte", 32'(D_byte), 32'(e.d));
                check_b("out_last", out_last, e.last);
`ifdef SERIAL_SUB_UFLOW_EN
                check_b("uflow", uflow, e.uf);
`endif
            end
        end
    end

    // Present one byte pair and hold it until accepted; returns at posedge+1.
    task automatic send_byte(input logic [7:0] a, input logic [7:0] b, input exp_t e);
        in_valid = 1'b1;
        A_byte   = a;
        B_byte   = b;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got no in_ready expected accept within 500 cycles");
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] d_exp, input logic uf_exp, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send_byte(a[8*i +: 8], b[8*i +: 8], '{d: d_exp[8*i +: 8], last: (i == 3), uf: (i == 3) && uf_exp});
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check_v(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        #3;
        check_b("rst_out_valid", out_valid, 1'b0);
        check_v("rst_d_byte", 32'(D_byte), 32'h0);
        check_b("rst_out_last", out_last, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_in_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // No borrow, borrow ripple, cross-word isolation
        send_word(32'h12345678, 32'h01020304, 32'h11325374, 1'b0, 0);
        send_word(32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 0);
        send_word(32'h00000005, 32'h00000002, 32'h00000003, 1'b0, 0);
        drain("drain_directed");

        // Idle gaps inside a word hold the borrow and count
        send_word(32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b0, 3);
        drain("drain_gaps");

        // Backpressure: hold out_ready low after byte 0 of the no-borrow word
        rdy_mode = 2;
        @(posedge clk);
        #2;
        send_byte(8'h78, 8'h04, '{d: 8'h74, last: 1'b0, uf: 1'b0});
        in_valid = 1'b1;
        A_byte   = 8'hAA;
        B_byte   = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_b("stall_in_ready", in_ready, 1'b0);
            check_b("stall_out_valid", out_valid, 1'b1);
            check_v("stall_d_held", 32'(D_byte), 32'h74);
            check_b("stall_busy", busy, 1'b1);
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
        send_byte(8'h56, 8'h03, '{d: 8'h53, last: 1'b0, uf: 1'b0});
        send_byte(8'h34, 8'h02, '{d: 8'h32, last: 1'b0, uf: 1'b0});
        send_byte(8'h12, 8'h01, '{d: 8'h11, last: 1'b1, uf: 1'b0});
        drain("drain_stall");

        // Back-to-back streaming: two words in eight cycles
        begin
            int t0;
            t0 = cycles;
            send_word(32'hDEADBEEF, 32'h0BADF00D, 32'hD2FFCEE2, 1'b0, 0);
            send_word(32'h00000001, 32'h80000000, 32'h80000001, 1'b1, 0);
            check_v("throughput_cycles", 32'(cycles - t0), 32'd8);
        end
        drain("drain_stream");

        // Reset mid-word after two accepted bytes
        send_byte(8'h11, 8'h22, '{d: 8'hEF, last: 1'b0, uf: 1'b0});
        send_byte(8'h11, 8'h22, '{d: 8'hEE, last: 1'b0, uf: 1'b0});
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_b("midrst_out_valid", out_valid, 1'b0);
        check_b("midrst_busy", busy, 1'b0);
        check_v("midrst_d_byte", 32'(D_byte), 32'h0);
        check_b("midrst_out_last", out_last, 1'b0);
        check_v("midrst_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_word(32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 0);
        drain("drain_after_reset");

        // Random words with random input gaps and output backpressure
        rdy_mode = 1;
        for (int w = 0; w < 3000; w++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom();
            b = (w % 4 == 0) ? a + 32'($urandom_range(0, 2)) : $urandom();
            send_word(a, b, a - b, (a < b), 2);
        end
        rdy_mode = 0;
        drain("drain_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
